led_seq_ctrl: RTL
=================

# led_seq_ctrl

Pattern sequencer for the 8-LED bank of the ispMACH 4256ZE breakout board. It drives the active-low `nled[7:0]` pins from a registered pattern engine with four display modes, stepped by an internal prescaler. A debounced active-low pushbutton cycles the modes. It replaces the static LED assignment in the top level and sits directly between the board pins and the board clock/reset.

## Interface
Parameters:
- `DIV`, default 1_200_000: clocks per pattern step; must be ≥2.
- `DB_CYCLES`, default 120_000: clocks the synchronized button must hold a new level before it is accepted; must be ≥2.

Ports:
- `clk` in 1: board clock. All logic is on the rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `nbtn` in 1: pushbutton, active-low, asynchronous to `clk`.
- `nled` out 8: LED drive, active-low, where 0 means lit. Equals the bitwise inverse of the internal registered `led[7:0]`, with no other logic on the path.
- `mode` out 2: current mode, for debug. 0 = BLINK, 1 = RUN, 2 = SCAN, 3 = COUNT.

## Operation
- **Reset** (`nrst`=0, asynchronous):
  - `mode`=1 (RUN), `led`=8'h01, so `nled`=8'hFE.
  - Prescaler = 0, SCAN direction = up.
  - Synchronizer flops = 1, debounced button = 1 (released), debounce counter = 0.
- **Synchronizer**: 2-flop sync on `nbtn`, producing `s2`.
- **Debounce**:
  - Counter clears whenever `s2` equals the debounced level.
  - Otherwise it increments. When it reaches DB_CYCLES-1 with `s2` still different, the debounced level takes `s2` and the counter clears.
  - Any pulse shorter than DB_CYCLES synchronized clocks is ignored.
- **Press event**: the debounced level goes 1→0. A release (0→1) does nothing. Holding the button produces exactly one press.
- **Mode advance** on a press: 0→1→2→3→0, applied on the same edge the debounced level falls. On that edge:
  - `led` loads the init pattern of the new mode.
  - The prescaler clears to 0.
  - SCAN direction is set to up.
- **Prescaler**: counts 0..DIV-1 and wraps. It raises a step strobe during the cycle when count = DIV-1.
- **Step behaviour per mode** (applied on the edge that ends the strobe cycle):
  - BLINK: init 8'hFF; each step `led` = ~`led`.
  - RUN: init 8'h01; each step rotates left by one, so 8'h80 becomes 8'h01.
  - SCAN: init 8'h01, direction up.
    - Up: shift left. If the shift result is 8'h80, direction becomes down on the same edge.
    - Down: shift right. If the result is 8'h01, direction becomes up.
    - Sequence: 01,02,…,80,40,…,01,02; period 14 steps.
  - COUNT: init 8'h00; each step `led`+1 modulo 256, so FF wraps to 00.
- **Press and step strobe in the same cycle**: the press wins. The init pattern loads and the prescaler clears; no step is applied.
- **Reset mid-operation**: immediate return to reset values regardless of mode, prescaler or debounce state.

## Timing
- All state is registered; `nled` and `mode` change only on `clk` edges or on asynchronous reset assertion.
- Step latency: `led` updates on the edge where the prescaler wraps from DIV-1 to 0. One step occurs every DIV clocks. The first step after reset or a mode change occurs on the DIV-th edge.
- Button latency: take edge 1 as the first edge that samples `nbtn`=0. If `nbtn` stays low, `mode`/`led` change on edge DB_CYCLES+2.
- Release is accepted DB_CYCLES+2 edges after `nbtn` returns high.
- A new press can be accepted only after that release has been accepted.

## Configuration
- Macro `LED_SEQ_SCAN_EN`.
- **Defined**: SCAN mode is present; the mode cycle is 0→1→2→3→0.
- **Undefined**:
  - SCAN logic and the direction flop are omitted.
  - The mode cycle is 0→1→3→0, and `mode` never reads 2.
  - All other behaviour is identical.

## Test plan
All scenarios use DIV=4 and DB_CYCLES=8.

1. **Reset and RUN stepping**:
   - Hold `nrst`=0: `nled`=8'hFE, `mode`=1.
   - Release reset, then run 32 clocks: `nled` steps FE,FD,FB,…,7F,FE, changing every 4 clocks.
2. **Debounce**:
   - `nbtn` low for 5 clocks, then high: `mode` stays 1.
   - `nbtn` low steadily: `mode`=2 and `nled`=8'hFE on edge 10. `mode` does not advance further while the button is held.
3. **SCAN bounce** (with the macro defined): over 15 steps, `led` goes 01,02,04,…,80,40,…,01,02. Direction reverses exactly at 80 and at 01.
4. **Mode cycle and COUNT wrap**:
   - Press until `mode`=3: `nled`=8'hFF.
   - After 256 steps, `led` returns to 00, and the step after that gives 01.
   - One more press gives BLINK: `nled`=8'h00, toggling to FF after 4 clocks.
5. **Collisions**:
   - A press lands in the strobe cycle: the init pattern loads and the next step comes 4 clocks later.
   - `nrst` pulsed low mid-COUNT: `nled`=8'hFE and `mode`=1 immediately, without waiting for an edge.
6. **Macro undefined**: presses starting from reset yield `mode` 3,0,1,3. `mode` never reads 2.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Mode-cycling LED pattern sequencer with a debounced pushbutton.
// Optional SCAN mode is built when LED_SEQ_SCAN_EN is defined.
module led_seq_ctrl #(
  parameter int DIV       = 1_200_000,
  parameter int DB_CYCLES = 120_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       nbtn,
  output logic [7:0] nled,
  output logic [1:0] mode
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DB_CYCLES);

  localparam logic [1:0] M_BLINK = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_SCAN  = 2'd2;
  localparam logic [1:0] M_COUNT = 2'd3;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [DW-1:0] r_dbcnt;
  logic [PW-1:0] r_pres;
  logic [7:0]    r_led;
  logic [1:0]    r_mode;

  logic          w_db_hit;
  logic          w_press;
  logic          w_strobe;
  logic [1:0]    w_mode_nx;
  logic [7:0]    w_init;
  logic [7:0]    w_step;

  assign nled = ~r_led;
  assign mode = r_mode;

  assign w_db_hit = (r_s2 != r_db) && (r_dbcnt == DB_LAST);
  assign w_press  = w_db_hit && !r_s2;
  assign w_strobe = (r_pres == PRE_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_db    <= 1'b1;
      r_dbcnt <= '0;
    end else begin
      r_s1 <= nbtn;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_dbcnt <= '0;
      end else if (w_db_hit) begin
        r_db    <= r_s2;
        r_dbcnt <= '0;
      end else begin
        r_dbcnt <= r_dbcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_mode_nx = M_RUN;
`ifdef LED_SEQ_SCAN_EN
    w_mode_nx = r_mode + 2'd1;
`else
    // SCAN is skipped: RUN jumps straight to COUNT
    unique case (r_mode)
      M_BLINK: w_mode_nx = M_RUN;
      M_RUN:   w_mode_nx = M_COUNT;
      default: w_mode_nx = M_BLINK;
    endcase
`endif
  end

  always_comb begin
    w_init = 8'h01;
    unique case (w_mode_nx)
      M_BLINK: w_init = 8'hFF;
      M_COUNT: w_init = 8'h00;
      default: w_init = 8'h01;
    endcase
  end

`ifdef LED_SEQ_SCAN_EN
  logic r_up;
  logic w_up_nx;
`endif

  always_comb begin
    w_step = r_led;
`ifdef LED_SEQ_SCAN_EN
    w_up_nx = r_up;
`endif
    unique case (r_mode)
      M_BLINK: w_step = ~r_led;
      M_RUN:   w_step = {r_led[6:0], r_led[7]};
`ifdef LED_SEQ_SCAN_EN
      M_SCAN: begin
        if (r_up) begin
          w_step = r_led << 1;
          if (w_step == 8'h80) w_up_nx = 1'b0;
        end else begin
          w_step = r_led >> 1;
          if (w_step == 8'h01) w_up_nx = 1'b1;
        end
      end
`endif
      M_COUNT: w_step = r_led + 8'd1;
      default: w_step = r_led;
    endcase
  end

  // a press outranks a step landing on the same edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode <= M_RUN;
      r_led  <= 8'h01;
      r_pres <= '0;
    end else if (w_press) begin
      r_mode <= w_mode_nx;
      r_led  <= w_init;
      r_pres <= '0;
    end else begin
      r_pres <= w_strobe ? '0 : r_pres + 1'b1;
      if (w_strobe) r_led <= w_step;
    end
  end

`ifdef LED_SEQ_SCAN_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_up <= 1'b1;
    end else if (w_press) begin
      r_up <= 1'b1;
    end else if (w_strobe) begin
      r_up <= w_up_nx;
    end
  end
`endif

endmodule
